// File: rtl/add_accumulator.sv
// Sequential front/back end for an external combinational adder: it sums a counted
// stream of operands through the adder and reports the final sum and an unsigned-overflow flag.
module add_accumulator #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_out,
    output logic [WIDTH-1:0] sum,
    output logic             sum_valid,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_remaining;
    logic             r_overflow;
    logic             r_sum_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic             w_beat;
    logic             w_carry;

    assign w_beat  = in_valid && r_in_ready;
    // A modulo sum smaller than the running-sum operand means the adder carried out.
    assign w_carry = (add_out < r_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sum       <= '0;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
            r_sum_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sum      <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        if (count != '0) begin
                            r_state     <= S_ACC;
                            r_remaining <= count;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            r_sum_valid <= 1'b1;
                        end
                    end
                end
                S_ACC: begin
                    if (w_beat) begin
                        r_sum       <= add_out;
                        r_overflow  <= r_overflow | w_carry;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_sum_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_sum_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_sum_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign add_a     = r_sum;
    assign add_b     = (r_state == S_ACC) ? in_data : '0;
    assign sum       = r_sum;
    assign sum_valid = r_sum_valid;
    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_add_accumulator.sv
// Bench for add_accumulator: models the adder, scoreboards completed jobs against an
// arithmetic reference, and runs directed plus randomized jobs.
module tb_add_accumulator;

    localparam int WIDTH = 64;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_out;
    logic [WIDTH-1:0] sum;
    logic             sum_valid;
    logic             busy;
    logic             overflow;

    add_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .sum(sum), .sum_valid(sum_valid), .busy(busy), .overflow(overflow)
    );

    assign add_out = add_a + add_b;

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             ovf;
        int               start_cyc;
        int               lat;
        int               id;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] ops[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    int               beats_seen = 0;
    int               beats_issued = 0;
    int               job_id = 0;
    bit               ready_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a final sum.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (in_ready) ready_seen = 1;
            if (in_valid && in_ready) beats_seen++;
            if (sum_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_sum_valid: got pulse with sum=%h, required no pulse", sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", sum, e.sum);
                    check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
                    check("busy_in_done", {63'd0, busy}, 64'd1);
                    check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                    if (e.lat >= 0)
                        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                    $display("[TB] job %0d done: sum=%h ovf=%0d (expected %h ovf=%0d)",
                             e.id, sum, overflow, e.sum, e.ovf);
                end
            end
        end
    end

    task automatic issue_start(input int n, output int k);
        @(posedge clk); #1;
        start = 1'b1;
        count = CNT_W'(n);
        k     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        count = '0;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready stayed %0d, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        beats_issued++;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d jobs pending, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // gap < 0: random 0..2 idle cycles between beats; ign: pulse start during the job.
    task automatic run_job(input int gap, input bit ign);
        exp_t             e;
        logic [WIDTH:0]   t;
        logic [WIDTH-1:0] part[$];
        logic [WIDTH-1:0] s = '0;
        bit               o = 0;
        int               k;
        int               g;
        foreach (ops[i]) begin
            t = {1'b0, s} + {1'b0, ops[i]};
            o = o | t[WIDTH];
            s = t[WIDTH-1:0];
            part.push_back(s);
        end
        issue_start(ops.size(), k);
        e.sum = s; e.ovf = o; e.start_cyc = k; e.id = job_id++;
        e.lat = (gap == 0) ? ops.size() + 1 : -1;
        sb.push_back(e);
        check("cleared_sum", sum, '0);
        check("cleared_ovf", {63'd0, overflow}, 64'd0);
        foreach (ops[i]) begin
            send_beat(ops[i]);
            check("partial_sum", sum, part[i]);
            if (i != ops.size() - 1) begin
                g = (gap < 0) ? $urandom_range(0, 2) : gap;
                for (int j = 0; j < g; j++) begin
                    if (ign && i == 0 && j == 0) begin
                        start = 1'b1;
                        count = CNT_W'(5);
                    end
                    @(posedge clk); #1;
                    start = 1'b0;
                    count = '0;
                end
            end
        end
        wait_drain();
    endtask

    initial begin
        start = 0; count = '0; in_valid = 0; in_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sum", sum, '0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        check("rst_sum_valid", {63'd0, sum_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;

        ops = '{64'h1, 64'h2};
        run_job(0, 0);

        ops = '{64'd5, 64'd7, 64'd9};
        run_job(2, 1);
        repeat (2) @(negedge clk);
        check("ignored_start_busy", {63'd0, busy}, 64'd0);

        ops = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2};
        run_job(0, 0);
        repeat (3) @(negedge clk);
        check("wrap_sum_held", sum, 64'h1);
        check("wrap_ovf_held", {63'd0, overflow}, 64'd1);

        ops.delete();
        ready_seen = 0;
        run_job(0, 0);
        check("zero_count_ready", {63'd0, ready_seen}, 64'd0);

        begin
            int k;
            issue_start(4, k);
            send_beat(64'd10);
            send_beat(64'd20);
            check("pre_reset_sum", sum, 64'd30);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("midrst_sum", sum, '0);
            check("midrst_busy", {63'd0, busy}, 64'd0);
            check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
            repeat (4) @(negedge clk);
        end
        ops = '{64'd7};
        run_job(0, 0);
        check("post_reset_sum", sum, 64'd7);

        for (int j = 0; j < 12; j++) begin
            logic [WIDTH-1:0] op;
            int n = $urandom_range(0, 6);
            ops.delete();
            for (int i = 0; i < n; i++) begin
                op = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) op = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                ops.push_back(op);
            end
            run_job((j % 3 == 0) ? 0 : -1, 0);
        end

        check("beat_count", 64'(beats_seen), 64'(beats_issued));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add_accumulator.md
# add_accumulator

Sequential front/back end for the 64-bit combinational `adder`. It accepts a start command with a beat count, then takes a stream of operands over a valid/ready handshake. It drives the adder's `a`/`b` inputs from its running sum and the current operand, and captures the adder's `out` back into the sum. It reports the final sum, a completion pulse and a sticky unsigned-overflow flag.

## Interface
- `WIDTH`, 64, datapath width; must match the adder.
- `CNT_W`, 8, width of the beat count.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin accumulation; sampled only in IDLE.
- `count`  in  CNT_W  number of operands to sum; sampled with `start`.
- `in_valid`  in  1  operand valid.
- `in_data`  in  WIDTH  operand.
- `in_ready`  out  1  block can accept operand.
- `add_a`  out  WIDTH  to adder `a`: running sum.
- `add_b`  out  WIDTH  to adder `b`: operand.
- `add_out`  in  WIDTH  from adder `out`.
- `sum`  out  WIDTH  registered running/final sum.
- `sum_valid`  out  1  one-cycle pulse: `sum` is final.
- `busy`  out  1  high in ACC and DONE.
- `overflow`  out  1  sticky unsigned carry-out seen this job.

## Operation
- **Clock and reset:** one clock (`clk`); `rst` is synchronous and active-high.
- **States:** IDLE, ACC, DONE.
- **Reset:** state goes to IDLE. `sum`=0, remaining=0, `overflow`=0, `sum_valid`=0, `in_ready`=0, `busy`=0. The reset is honoured in any state and abandons a job in progress.
- **IDLE, `start`=1 with `count`>0:**
  - `sum`←0, `overflow`←0, remaining←`count`.
  - Go to ACC.
- **IDLE, `start`=1 with `count`=0:**
  - `sum`←0, `overflow`←0.
  - Go to DONE; no operands are consumed.
- **IDLE, `start`=0:** stay; `sum` and `overflow` keep their last values.
- **ACC:**
  - `in_ready`=1.
  - A beat is accepted when `in_valid`&&`in_ready` at a rising edge.
  - On a beat: `sum`←`add_out`; `overflow`←`overflow` | (`add_out` < `add_a`); remaining←remaining−1.
  - On the beat taken when remaining=1: go to DONE.
  - `in_valid`=0 causes a stall in ACC with no change.
- **DONE:**
  - `sum_valid`=1 for exactly one cycle, `in_ready`=0.
  - Next state is IDLE unconditionally.
- **`start` outside IDLE:** ignored, including in DONE. There is no queuing.
- **Adder drive:**
  - `add_a`=`sum` at all times.
  - `add_b`=`in_data` in ACC; 0 otherwise.
- **Arithmetic:**
  - Modulo 2^WIDTH, unsigned; the result wraps.
  - `overflow` flags any carry-out during the job.
- **Count width:** max job = 2^CNT_W−1 beats.

## Timing
- `in_ready` and `busy` are registered-state decodes. `in_ready` rises the cycle after `start` is sampled.
- Latency:
  - `sum_valid` is asserted in the cycle after the last accepted beat.
  - For a `count`=0 job, it is asserted the cycle after `start`.
- Throughput: one operand per cycle while `in_valid` stays high. N beats take N+2 cycles from `start` to the `sum_valid` cycle inclusive.
- `sum` updates on the same edge that accepts a beat. It is stable during DONE and held through IDLE until the next `start`.
- The adder path is combinational: `add_a` → `add_out` must settle within one cycle.
- `rst` asserted in the same cycle as `start` or a beat: reset wins; the beat is not consumed.

## Test plan
- **Reset:** hold `rst` 2 cycles. Required: `sum`=0, `overflow`=0, `sum_valid`=0, `in_ready`=0, `busy`=0.
- **Basic sum:** `start`, `count`=2, then beats 64'h01, 64'h02 back-to-back. Required:
  - `sum` reads 1, then 3.
  - `sum_valid` pulses once, 1 cycle after the 2nd beat.
  - `overflow`=0.
- **Backpressure gaps:** `count`=3, operands 5, 7, 9 with `in_valid` low for 2 cycles between beats. Required:
  - `sum`=21.
  - No beat is accepted while `in_valid`=0.
  - Total of 3 beats consumed.
- **Wrap:** `count`=2, operands 64'hFFFF_FFFF_FFFF_FFFF, 64'h2. Required: `sum`=64'h1, `overflow`=1 and held until the next `start`.
- **Zero count and ignored start:**
  - `start` with `count`=0. Required: `sum_valid` next cycle, `sum`=0, `in_ready` never high.
  - Then `start` with `count`=5 pulsed during ACC. Required: ignored; the job ends after its original count.
- **Reset mid-operation:** `count`=4, accept 2 beats (10, 20), assert `rst`. Required: IDLE, `sum`=0, no `sum_valid` pulse. A new `count`=1 job with operand 7 then yields `sum`=7.
